// File: rtl/spmv_fp16_mul.sv
// Two-stage FP16 multiplier feeding the SpMV accumulator; truncating, no NaN/Inf semantics.
// Optional macro SPMV_MUL_SAT_EN: overflow saturates to max finite instead of infinity.
module spmv_fp16_mul (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] mat_val,
    input  logic [15:0] vec_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] mul_result,
    output logic        ovf_flag,
    output logic        unf_flag
);

`ifdef SPMV_MUL_SAT_EN
    localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
    localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

    logic        s1_valid_r;
    logic        s1_sign_r;
    logic [6:0]  s1_exp_r;
    logic [21:0] s1_prod_r;
    logic        s1_zero_r;

    logic        out_valid_r;
    logic [15:0] result_r;
    logic        s2_ovf_r;
    logic        s2_unf_r;
    logic        ovf_flag_r;
    logic        unf_flag_r;

    logic        adv2_s;
    logic        in_ready_s;
    logic        out_fire_s;
    logic [21:0] prod_s;
    logic [6:0]  exp_sum_s;
    logic        zero_s;
    logic [6:0]  norm_exp_s;
    logic [9:0]  norm_mant_s;
    logic [15:0] norm_result_s;
    logic        norm_ovf_s;
    logic        norm_unf_s;

    // Handshake: S2 frees when empty or drained; S1 frees when empty or moving into S2.
    always_comb begin
        adv2_s     = !out_valid_r || out_ready;
        in_ready_s = !s1_valid_r || adv2_s;
        out_fire_s = out_valid_r && out_ready;
    end

    // Stage-1 datapath: sign, biased exponent sum (two's complement), raw mantissa product.
    always_comb begin
        prod_s    = 22'({1'b1, mat_val[9:0]}) * 22'({1'b1, vec_val[9:0]});
        exp_sum_s = 7'(mat_val[14:10]) + 7'(vec_val[14:10]) - 7'd15;
        zero_s    = (mat_val[14:10] == 5'd0) || (vec_val[14:10] == 5'd0);
    end

    // Stage-1 register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_exp_r   <= 7'd0;
            s1_prod_r  <= 22'd0;
            s1_zero_r  <= 1'b0;
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_sign_r <= mat_val[15] ^ vec_val[15];
                s1_exp_r  <= exp_sum_s;
                s1_prod_r <= prod_s;
                s1_zero_r <= zero_s;
            end
        end
    end

    // Normalization: one-bit shift on carry-out, then range check on the final exponent.
    always_comb begin
        norm_exp_s    = s1_exp_r;
        norm_mant_s   = s1_prod_r[19:10];
        norm_result_s = 16'h0000;
        norm_ovf_s    = 1'b0;
        norm_unf_s    = 1'b0;
        if (s1_prod_r[21]) begin
            norm_exp_s  = s1_exp_r + 7'd1;
            norm_mant_s = s1_prod_r[20:11];
        end else begin
            norm_exp_s  = s1_exp_r;
            norm_mant_s = s1_prod_r[19:10];
        end
        if (s1_zero_r) begin
            norm_result_s = 16'h0000;
        end else if ($signed(norm_exp_s) < 7'sd1) begin
            norm_result_s = 16'h0000;
            norm_unf_s    = 1'b1;
        end else if ($signed(norm_exp_s) > 7'sd30) begin
            norm_result_s = {s1_sign_r, OVF_MAG};
            norm_ovf_s    = 1'b1;
        end else begin
            norm_result_s = {s1_sign_r, norm_exp_s[4:0], norm_mant_s};
        end
    end

    // Stage-2 register: holds its product while downstream stalls.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            out_valid_r <= 1'b0;
            result_r    <= 16'h0000;
            s2_ovf_r    <= 1'b0;
            s2_unf_r    <= 1'b0;
        end else if (adv2_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                result_r <= norm_result_s;
                s2_ovf_r <= norm_ovf_s;
                s2_unf_r <= norm_unf_s;
            end
        end
    end

    // Sticky range flags, raised as the offending product is handed downstream.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ovf_flag_r <= 1'b0;
            unf_flag_r <= 1'b0;
        end else if (out_fire_s) begin
            ovf_flag_r <= ovf_flag_r | s2_ovf_r;
            unf_flag_r <= unf_flag_r | s2_unf_r;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign mul_result = result_r;
    assign ovf_flag   = ovf_flag_r;
    assign unf_flag   = unf_flag_r;

endmodule

// File: doc/spmv_fp16_mul.md
SPMV_FP16_MUL -- requirements
Module: spmv_fp16_mul

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: i_clk and i_rstn.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_rstn  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operand pair on mat_val/vec_val is valid this cycle.
REQ-005 in_ready  output  1  block accepts the operand pair this cycle.
REQ-006 mat_val  input  16  FP16 matrix element (sign[15], exponent[14:10], mantissa[9:0]).
REQ-007 vec_val  input  16  FP16 vector element, same format.
REQ-008 out_valid  output  1  mul_result holds a valid product.
REQ-009 out_ready  input  1  downstream adder accepts mul_result this cycle.
REQ-010 mul_result  output  16  FP16 product, fed to the accumulator adder's mul_result input.
REQ-011 ovf_flag  output  1  sticky: an accepted product overflowed.
REQ-012 unf_flag  output  1  sticky: an accepted product underflowed to zero.

Function
REQ-013 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-014 Pipeline SHALL have two register stages (S1: sign, 7-bit signed exponent sum, 22-bit mantissa product, zero flag; S2: normalized mul_result); latency is 2 cycles from input transfer to out_valid, with no backpressure.
REQ-015 Stage advance: adv2 = !out_valid || out_ready; S1 SHALL move into S2 when S1 valid && adv2; in_ready = !S1_valid || adv2 (combinational).
REQ-016 Throughput SHALL be one product per cycle when out_ready is held high; no bubbles, no reordering.
REQ-017 While out_valid && !out_ready, mul_result and out_valid SHALL hold stable.
REQ-018 Sign SHALL be mat_val[15] XOR vec_val[15].
REQ-019 If either operand exponent is 5'b0 (zero/denormal), result SHALL be 16'h0000 and no flag SHALL set.
REQ-020 Mantissa product P = {1,mant_a} * {1,mant_b} (22 bits); exponent E = exp_a + exp_b - 15.
REQ-021 If P[21]=1: mantissa = P[20:11], E = E + 1; else mantissa = P[19:10]; truncation, no rounding.
REQ-022 If final E <= 0, result SHALL be 16'h0000 and unf_flag SHALL set when that product leaves S2.
REQ-023 If final E >= 31, result SHALL follow REQ-029 and ovf_flag SHALL set when that product leaves S2.
REQ-024 Exponent-31 inputs SHALL be treated as ordinary normalized values (no NaN/Inf semantics).
REQ-025 Simultaneous input and output transfer in the same cycle SHALL both complete.

Reset
REQ-026 On i_rstn low, regardless of clock: S1/S2 valid bits, out_valid, ovf_flag, unf_flag SHALL clear to 0 and mul_result to 16'h0000; in-flight operands are discarded.
REQ-027 After reset deassertion, in_ready SHALL be 1 in the first cycle.
REQ-028 Sticky flags SHALL clear only on reset.

Configuration
REQ-029 Macro SPMV_MUL_SAT_EN: defined -> overflow result SHALL be {sign,15'h7BFF} (max finite); undefined -> {sign,15'h7C00} (infinity).

Verification
REQ-030 0x3E00 x 0x4000 (1.5x2.0), out_ready=1 -> mul_result=0x4200 exactly 2 cycles after transfer, flags 0.
REQ-031 0xC000 x 0x4200 (-2x3) -> 0xC600; 0x0000 x 0x4200 -> 0x0000, unf_flag stays 0.
REQ-032 0x7800 x 0x4000 -> 0x7C00 without SPMV_MUL_SAT_EN, 0x7BFF with it; ovf_flag=1 thereafter; 0x0400 x 0x0400 -> 0x0000, unf_flag=1.
REQ-033 Four back-to-back pairs with out_ready low for 3 cycles -> in_ready drops after 2 accepted, mul_result held stable, all four products emerge in order once out_ready=1.
REQ-034 Assert i_rstn low mid-stream with S1 and S2 full -> out_valid=0, mul_result=0x0000 immediately; no stale product after release.
